// File: rtl/instr_stream_tx.sv
// ---------------------------------------------------------------------------
// instr_stream_tx
//
// Instruction-side transmitter for the experiment FSM. The host loads a
// program into a local single-clock BRAM through a plain write port. On
// start, words 0..len-1 are read back and streamed out as AXI-Stream with
// full tvalid/tready backpressure and tlast on the final word.
//
// Ports
//   clk               system clock
//   rst               synchronous active-low reset
//   wr_en/wr_addr/wr_data   host program write port (dropped while busy)
//   prog_len          number of words to send, sampled at start, clipped to DEPTH
//   start             begin streaming (level sensitive, acts only in IDLE)
//   abort             cancel the stream in progress
//   instr_axis_*      AXI-Stream master (tdata = {opcode[31:16], data[15:0]})
//   busy              high from start acceptance until done/abort
//   done              1-cycle pulse after the final handshake
//   aborted           1-cycle pulse when an abort takes effect
//   wr_err            sticky: host write attempted while busy
//   sent_cnt          handshakes completed in the current/last run
// ---------------------------------------------------------------------------
module instr_stream_tx #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] instr_axis_tdata,
  output logic              instr_axis_tvalid,
  output logic              instr_axis_tlast,
  input  logic              instr_axis_tready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              wr_err,
  output logic [ADDR_W:0]   sent_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};
  localparam logic [DATA_W:0] ENTRY_ZERO_C = {(DATA_W+1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Control state
  state_t            state_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   rd_ptr_r;
  logic              busy_r;
  logic              done_r;
  logic              aborted_r;
  logic              wr_err_r;
  logic [ADDR_W:0]   sent_cnt_r;

  // Program memory and its read pipeline stage
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;
  logic              inflight_r;
  logic              inflight_last_r;

  // Two-entry output FIFO: head_r is the word presented on the bus,
  // tail_r holds the second entry. Entries are {last, data}.
  logic [DATA_W:0]   head_r;
  logic [DATA_W:0]   tail_r;
  logic [1:0]        fifo_cnt_r;
  logic              valid_r;

  // Combinational helpers
  logic [ADDR_W:0]   len_clip_s;
  logic              pop_s;
  logic              push_s;
  logic              abort_take_s;
  logic [2:0]        level_s;
  logic              rd_issue_s;
  logic              rd_last_s;
  logic              wr_accept_s;
  logic              final_hs_s;
  logic [DATA_W:0]   push_entry_s;
  logic [DATA_W:0]   head_n_s;
  logic [DATA_W:0]   tail_n_s;
  logic [1:0]        fifo_cnt_n_s;

  // Clip requested length to the memory depth
  always_comb begin
    len_clip_s = prog_len;
    if (prog_len > DEPTH_C) begin
      len_clip_s = DEPTH_C;
    end else begin
      len_clip_s = prog_len;
    end
  end

  assign pop_s        = valid_r & instr_axis_tready;
  assign push_s       = inflight_r;
  assign abort_take_s = abort & (state_r != ST_IDLE);
  assign wr_accept_s  = wr_en & ~busy_r;
  assign rd_last_s    = (rd_ptr_r == (len_r - ONE_C));
  assign final_hs_s   = pop_s & head_r[DATA_W];
  assign push_entry_s = {inflight_last_r, rd_data_r};

  // FIFO occupancy after this cycle's pop plus the read already in flight;
  // a new read is only issued when its data is guaranteed a free slot.
  assign level_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};

  // Read issue decision for the stream port of the BRAM
  always_comb begin
    rd_issue_s = 1'b0;
    if ((state_r == ST_STREAM) && !abort && (rd_ptr_r < len_r) && (level_s < 3'd2)) begin
      rd_issue_s = 1'b1;
    end else begin
      rd_issue_s = 1'b0;
    end
  end

  // Next-state of the output FIFO (flush on abort, otherwise push/pop)
  always_comb begin
    head_n_s     = head_r;
    tail_n_s     = tail_r;
    fifo_cnt_n_s = fifo_cnt_r;
    if (abort_take_s) begin
      head_n_s     = ENTRY_ZERO_C;
      tail_n_s     = ENTRY_ZERO_C;
      fifo_cnt_n_s = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (fifo_cnt_r == 2'd0) begin
            head_n_s     = push_entry_s;
            fifo_cnt_n_s = 2'd1;
          end else begin
            tail_n_s     = push_entry_s;
            fifo_cnt_n_s = 2'd2;
          end
        end
        2'b01: begin
          if (fifo_cnt_r == 2'd2) begin
            head_n_s     = tail_r;
            tail_n_s     = ENTRY_ZERO_C;
            fifo_cnt_n_s = 2'd1;
          end else begin
            // Going empty: zero the head so tdata/tlast read 0 when idle
            head_n_s     = ENTRY_ZERO_C;
            fifo_cnt_n_s = 2'd0;
          end
        end
        2'b11: begin
          if (fifo_cnt_r == 2'd2) begin
            head_n_s = tail_r;
            tail_n_s = push_entry_s;
          end else begin
            head_n_s = push_entry_s;
          end
        end
        default: begin
          head_n_s     = head_r;
          tail_n_s     = tail_r;
          fifo_cnt_n_s = fifo_cnt_r;
        end
      endcase
    end
  end

  // Program BRAM: host write port A, stream read port B (read-first)
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_issue_s) begin
      rd_data_r <= mem_r[rd_ptr_r[ADDR_W-1:0]];
    end
  end

  // Output FIFO and read pipeline registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r          <= ENTRY_ZERO_C;
      tail_r          <= ENTRY_ZERO_C;
      fifo_cnt_r      <= 2'd0;
      valid_r         <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      head_r          <= head_n_s;
      tail_r          <= tail_n_s;
      fifo_cnt_r      <= fifo_cnt_n_s;
      valid_r         <= (fifo_cnt_n_s != 2'd0);
      inflight_r      <= rd_issue_s;
      inflight_last_r <= rd_last_s;
    end
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      len_r      <= ZERO_C;
      rd_ptr_r   <= ZERO_C;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
      wr_err_r   <= 1'b0;
      sent_cnt_r <= ZERO_C;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      // An aborted final beat still completed on the bus, so it is counted
      if (pop_s) begin
        sent_cnt_r <= sent_cnt_r + ONE_C;
      end
      if (wr_en && busy_r) begin
        wr_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sent_cnt_r <= ZERO_C;
            if (len_clip_s != ZERO_C) begin
              len_r    <= len_clip_s;
              rd_ptr_r <= ZERO_C;
              busy_r   <= 1'b1;
              wr_err_r <= 1'b0;
              state_r  <= ST_STREAM;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (abort) begin
            busy_r    <= 1'b0;
            aborted_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            if (rd_issue_s) begin
              rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            if (final_hs_s) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else if (rd_ptr_r == len_r) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            busy_r    <= 1'b0;
            aborted_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else if (final_hs_s) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_axis_tdata  = head_r[DATA_W-1:0];
  assign instr_axis_tlast  = head_r[DATA_W];
  assign instr_axis_tvalid = valid_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign aborted           = aborted_r;
  assign wr_err            = wr_err_r;
  assign sent_cnt          = sent_cnt_r;

endmodule

// File: tb/tb_instr_stream_tx.sv
module tb_instr_stream_tx;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] instr_axis_tdata;
  logic              instr_axis_tvalid;
  logic              instr_axis_tlast;
  logic              instr_axis_tready;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              wr_err;
  logic [ADDR_W:0]   sent_cnt;

  always #5 clk = ~clk;

  instr_stream_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start), .abort(abort),
    .instr_axis_tdata(instr_axis_tdata), .instr_axis_tvalid(instr_axis_tvalid),
    .instr_axis_tlast(instr_axis_tlast), .instr_axis_tready(instr_axis_tready),
    .busy(busy), .done(done), .aborted(aborted), .wr_err(wr_err), .sent_cnt(sent_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the program memory should hold
  logic [31:0] model_mem [DEPTH];

  // Observations of one run
  logic [31:0] got_data [$];
  bit          got_last [$];
  int          hs_cyc [$];
  int done_cnt, done_cyc, abrt_cnt, abrt_cyc, first_valid, busy_first, stab_err, valid_after_end;
  bit timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int n, input bit incr);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(i);
      wr_data = incr ? (32'hA000_0000 + 32'(i)) : $urandom;
      model_mem[i] = wr_data;
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Starts a run and records every beat; mode 0: tready=1, 1: toggle, 2: random
  task automatic run_stream(input int len_in, input int mode, input int abort_after,
                            input int inj_cyc, input logic [7:0] inj_addr, input logic [31:0] inj_data);
    logic [31:0] prev_data;
    bit prev_last, prev_stall, abort_sent;
    int cyc, end_cyc;
    got_data.delete(); got_last.delete(); hs_cyc.delete();
    done_cnt = 0; done_cyc = -1; abrt_cnt = 0; abrt_cyc = -1; first_valid = -1;
    busy_first = -1; stab_err = 0; valid_after_end = 0;
    prev_stall = 1'b0; prev_data = 32'h0; prev_last = 1'b0; abort_sent = 1'b0;
    prog_len = 9'(len_in);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    end_cyc = -1;
    while (cyc < 3000) begin
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (aborted) begin abrt_cnt++; if (abrt_cyc < 0) abrt_cyc = cyc; end
      if (busy && busy_first < 0) busy_first = cyc;
      if (instr_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!instr_axis_tvalid || instr_axis_tdata !== prev_data || instr_axis_tlast !== prev_last))
        stab_err++;
      if (end_cyc < 0 && (done || aborted)) end_cyc = cyc;
      if (end_cyc >= 0 && instr_axis_tvalid) valid_after_end++;
      if (end_cyc >= 0 && cyc >= end_cyc + 4) break;
      case (mode)
        0: instr_axis_tready = 1'b1;
        1: instr_axis_tready = (cyc % 2 == 0);
        default: instr_axis_tready = 1'($urandom_range(0, 1));
      endcase
      abort = 1'b0;
      if (abort_after >= 0 && !abort_sent && got_data.size() == abort_after) begin
        abort = 1'b1;
        instr_axis_tready = 1'b0;
        abort_sent = 1'b1;
      end
      wr_en   = (cyc == inj_cyc);
      wr_addr = inj_addr;
      wr_data = inj_data;
      if (instr_axis_tvalid && instr_axis_tready) begin
        got_data.push_back(instr_axis_tdata);
        got_last.push_back(instr_axis_tlast);
        hs_cyc.push_back(cyc + 1);
      end
      prev_stall = instr_axis_tvalid && !instr_axis_tready;
      prev_data  = instr_axis_tdata;
      prev_last  = instr_axis_tlast;
      tick();
      cyc++;
    end
    timed_out = (end_cyc < 0);
    abort = 1'b0;
    wr_en = 1'b0;
    instr_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++; if (instr_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %0b want 0", instr_axis_tvalid); end
    n_cmp++; if (instr_axis_tdata !== 32'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", instr_axis_tdata); end
    n_cmp++; if (instr_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %0b want 0", instr_axis_tlast); end
    n_cmp++; if ({busy, done, aborted, wr_err} !== 4'b0000) begin n_err++; $display("FAIL reset_status: got %b want 0000", {busy, done, aborted, wr_err}); end
    n_cmp++; if (sent_cnt !== 9'd0) begin n_err++; $display("FAIL reset_sent_cnt: got %0d want 0", sent_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load_prog(8, 1'b1);
    run_stream(8, 0, -1, -1, 8'd0, 32'd0);
    n_cmp++; if (timed_out) begin n_err++; $display("FAIL basic_timeout: run never ended"); end
    n_cmp++; if (got_data.size() != 8) begin n_err++; $display("FAIL basic_count: got %0d beats want 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      n_cmp++;
      if (got_data[i] !== (32'hA000_0000 + 32'(i)) || got_last[i] !== (i == 7) || hs_cyc[i] != 3 + i) begin
        n_err++;
        $display("FAIL basic_beat[%0d]: got %h last=%0b cyc=%0d want %h last=%0b cyc=%0d",
                 i, got_data[i], got_last[i], hs_cyc[i], 32'hA000_0000 + 32'(i), (i == 7), 3 + i);
      end
    end
    n_cmp++; if (first_valid != 2) begin n_err++; $display("FAIL basic_latency: tvalid first at %0d want 2", first_valid); end
    n_cmp++; if (busy_first != 0) begin n_err++; $display("FAIL basic_busy: busy first at %0d want 0", busy_first); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 10) begin n_err++; $display("FAIL basic_done: count %0d at %0d want 1 at 10", done_cnt, done_cyc); end
    n_cmp++; if (sent_cnt !== 9'd8) begin n_err++; $display("FAIL basic_sent_cnt: got %0d want 8", sent_cnt); end
    n_cmp++; if (busy !== 1'b0 || valid_after_end != 0) begin n_err++; $display("FAIL basic_idle: busy=%0b late_valid=%0d want 0/0", busy, valid_after_end); end
  endtask

  task automatic test_backpressure();
    run_stream(8, 1, -1, -1, 8'd0, 32'd0);
    n_cmp++; if (got_data.size() != 8 || timed_out) begin n_err++; $display("FAIL bp_count: got %0d beats timeout=%0b want 8/0", got_data.size(), timed_out); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      n_cmp++;
      if (got_data[i] !== (32'hA000_0000 + 32'(i)) || got_last[i] !== (i == 7)) begin
        n_err++; $display("FAIL bp_beat[%0d]: got %h last=%0b want %h last=%0b", i, got_data[i], got_last[i], 32'hA000_0000 + 32'(i), (i == 7));
      end
    end
    n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL bp_stable: %0d stall violations want 0", stab_err); end
    n_cmp++; if (done_cnt != 1 || got_data.size() == 0 || done_cyc != hs_cyc[hs_cyc.size()-1]) begin
      n_err++; $display("FAIL bp_done: count %0d at %0d want 1 right after final handshake", done_cnt, done_cyc); end
    n_cmp++; if (sent_cnt !== 9'd8) begin n_err++; $display("FAIL bp_sent_cnt: got %0d want 8", sent_cnt); end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 40);
      load_prog(n, 1'b0);
      run_stream(n, 2, -1, -1, 8'd0, 32'd0);
      n_cmp++; if (got_data.size() != n || timed_out) begin n_err++; $display("FAIL rand%0d_count: got %0d beats want %0d", r, got_data.size(), n); end
      for (int i = 0; i < n && i < got_data.size(); i++) begin
        n_cmp++;
        if (got_data[i] !== model_mem[i] || got_last[i] !== (i == n - 1)) begin
          n_err++; $display("FAIL rand%0d_beat[%0d]: got %h last=%0b want %h last=%0b", r, i, got_data[i], got_last[i], model_mem[i], (i == n - 1));
        end
      end
      n_cmp++; if (stab_err != 0 || done_cnt != 1 || sent_cnt !== 9'(n)) begin
        n_err++; $display("FAIL rand%0d_status: stall_err=%0d done=%0d sent=%0d want 0/1/%0d", r, stab_err, done_cnt, sent_cnt, n); end
    end
  endtask

  task automatic test_len0();
    run_stream(0, 0, -1, -1, 8'd0, 32'd0);
    n_cmp++; if (done_cnt != 1 || done_cyc != 0) begin n_err++; $display("FAIL len0_done: count %0d at %0d want 1 at 0", done_cnt, done_cyc); end
    n_cmp++; if (first_valid != -1 || got_data.size() != 0) begin n_err++; $display("FAIL len0_valid: tvalid at %0d beats %0d want none", first_valid, got_data.size()); end
    n_cmp++; if (busy_first != -1 || sent_cnt !== 9'd0) begin n_err++; $display("FAIL len0_busy: busy at %0d sent %0d want none/0", busy_first, sent_cnt); end
  endtask

  task automatic test_clip();
    int lasts;
    load_prog(DEPTH, 1'b0);
    run_stream(300, 2, -1, -1, 8'd0, 32'd0);
    n_cmp++; if (got_data.size() != DEPTH || timed_out) begin n_err++; $display("FAIL clip_count: got %0d beats want 256", got_data.size()); end
    lasts = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_last[i]) lasts++;
      n_cmp++;
      if (i >= DEPTH || got_data[i] !== model_mem[i]) begin
        n_err++; $display("FAIL clip_beat[%0d]: got %h want %h", i, got_data[i], (i < DEPTH) ? model_mem[i] : 32'h0);
      end
    end
    n_cmp++; if (lasts != 1 || got_data.size() == 0 || !got_last[got_data.size()-1]) begin n_err++; $display("FAIL clip_tlast: %0d tlast beats want 1 on final", lasts); end
    n_cmp++; if (sent_cnt !== 9'd256 || done_cnt != 1) begin n_err++; $display("FAIL clip_status: sent %0d done %0d want 256/1", sent_cnt, done_cnt); end
  endtask

  task automatic test_abort();
    int lasts;
    load_prog(16, 1'b0);
    run_stream(16, 0, 5, -1, 8'd0, 32'd0);
    lasts = 0;
    foreach (got_last[i]) if (got_last[i]) lasts++;
    n_cmp++; if (got_data.size() != 5 || lasts != 0) begin n_err++; $display("FAIL abort_beats: got %0d beats %0d tlast want 5/0", got_data.size(), lasts); end
    n_cmp++; if (abrt_cnt != 1 || got_data.size() != 5 || abrt_cyc != hs_cyc[4] + 1) begin
      n_err++; $display("FAIL abort_pulse: count %0d at %0d want 1 the cycle after abort", abrt_cnt, abrt_cyc); end
    n_cmp++; if (done_cnt != 0 || valid_after_end != 0) begin n_err++; $display("FAIL abort_quiet: done %0d late_valid %0d want 0/0", done_cnt, valid_after_end); end
    n_cmp++; if (sent_cnt !== 9'd5 || busy !== 1'b0) begin n_err++; $display("FAIL abort_status: sent %0d busy %0b want 5/0", sent_cnt, busy); end
    run_stream(16, 2, -1, -1, 8'd0, 32'd0);
    n_cmp++; if (got_data.size() != 16 || done_cnt != 1) begin n_err++; $display("FAIL abort_restart_count: got %0d beats done %0d want 16/1", got_data.size(), done_cnt); end
    for (int i = 0; i < 16 && i < got_data.size(); i++) begin
      n_cmp++;
      if (got_data[i] !== model_mem[i] || got_last[i] !== (i == 15)) begin
        n_err++; $display("FAIL abort_restart_beat[%0d]: got %h want %h", i, got_data[i], model_mem[i]);
      end
    end
  endtask

  task automatic test_wr_err();
    load_prog(12, 1'b0);
    run_stream(12, 0, -1, 3, 8'd5, ~model_mem[5]);
    n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL wrerr_set: got %0b want 1", wr_err); end
    for (int pass = 0; pass < 2; pass++) begin
      n_cmp++; if (got_data.size() != 12) begin n_err++; $display("FAIL wrerr_count%0d: got %0d beats want 12", pass, got_data.size()); end
      for (int i = 0; i < 12 && i < got_data.size(); i++) begin
        n_cmp++;
        if (got_data[i] !== model_mem[i]) begin n_err++; $display("FAIL wrerr_beat%0d[%0d]: got %h want %h", pass, i, got_data[i], model_mem[i]); end
      end
      if (pass == 0) run_stream(12, 2, -1, -1, 8'd0, 32'd0);
    end
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL wrerr_clear: got %0b want 0", wr_err); end
  endtask

  task automatic test_reset_mid();
    load_prog(16, 1'b0);
    instr_axis_tready = 1'b0;
    prog_len = 9'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    wr_en = 1'b1; wr_addr = 8'd2; wr_data = ~model_mem[2];
    tick();
    wr_en = 1'b0;
    n_cmp++; if (instr_axis_tvalid !== 1'b1 || wr_err !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: tvalid %0b wr_err %0b busy %0b want 1/1/1", instr_axis_tvalid, wr_err, busy); end
    rst = 1'b0;
    tick();
    n_cmp++; if ({instr_axis_tvalid, instr_axis_tlast, busy, done, aborted, wr_err} !== 6'b0 || instr_axis_tdata !== 32'h0 || sent_cnt !== 9'd0) begin
      n_err++; $display("FAIL rstmid_outputs: flags %b tdata %h sent %0d want all 0", {instr_axis_tvalid, instr_axis_tlast, busy, done, aborted, wr_err}, instr_axis_tdata, sent_cnt); end
    rst = 1'b1;
    instr_axis_tready = 1'b1;
    tick();
    run_stream(16, 2, -1, -1, 8'd0, 32'd0);
    n_cmp++; if (got_data.size() != 16 || done_cnt != 1) begin n_err++; $display("FAIL rstmid_count: got %0d beats done %0d want 16/1", got_data.size(), done_cnt); end
    for (int i = 0; i < 16 && i < got_data.size(); i++) begin
      n_cmp++;
      if (got_data[i] !== model_mem[i] || got_last[i] !== (i == 15)) begin
        n_err++; $display("FAIL rstmid_beat[%0d]: got %h want %h", i, got_data[i], model_mem[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = 32'd0; prog_len = 9'd0;
    start = 1'b0; abort = 1'b0; instr_axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_len0();
    test_clip();
    test_abort();
    test_wr_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
